// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt controller for the single-cycle core.
// Generates the core clock-enable and supports free-run, single-step, PC
// breakpoints and, with RUNCTL_LIMIT_EN defined, an auto-halt cycle budget
// (adds the cycle_limit_i port).
module cpu_run_ctrl #(
  parameter  int XLEN   = 32,
  parameter  int CNT_W  = 32,
  parameter  int NUM_BP = 2,
  localparam int BPI_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             halt_i,
  input  logic             bp_wr_en_i,
  input  logic [BPI_W-1:0] bp_wr_idx_i,
  input  logic [XLEN-1:0]  bp_wr_addr_i,
  input  logic             bp_wr_valid_i,
  input  logic [XLEN-1:0]  pc_i,
`ifdef RUNCTL_LIMIT_EN
  input  logic [CNT_W-1:0] cycle_limit_i,
`endif
  output logic             cpu_en_o,
  output logic             halted_o,
  output logic [2:0]       halt_cause_o,
  output logic [BPI_W-1:0] bp_hit_idx_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'b000,
    CAUSE_HALT  = 3'b001,
    CAUSE_STEP  = 3'b010,
    CAUSE_BP    = 3'b011,
    CAUSE_LIMIT = 3'b100
  } cause_e;

  state_e             state_q, state_d;
  cause_e             cause_q, cause_d;
  logic [BPI_W-1:0]   bp_idx_q, bp_idx_d;
  logic               skip_q, skip_d;
  logic [CNT_W-1:0]   cycle_cnt_q;
  logic [NUM_BP-1:0]  bp_valid_q;
  logic [XLEN-1:0]    bp_addr_q [NUM_BP];

  logic [NUM_BP-1:0]  bp_hit_vec;
  logic               bp_match;
  logic [BPI_W-1:0]   bp_first_idx;
  logic               limit_last;
  logic               cpu_en;
  logic               bp_wr_sel;

  // An out-of-range index (NUM_BP not a power of two) writes nothing.
  assign bp_wr_sel = bp_wr_en_i && (32'(bp_wr_idx_i) < NUM_BP);

  // Breakpoint valid bits: cleared by reset, written one entry at a time.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_valid_q <= '0;
    end else if (bp_wr_sel) begin
      bp_valid_q[bp_wr_idx_i] <= bp_wr_valid_i;
    end
  end

  // Breakpoint addresses: storage only, qualified by the valid bits.
  // NOTE: no reset on this array -- an entry is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (bp_wr_sel) begin
      bp_addr_q[bp_wr_idx_i] <= bp_wr_addr_i;
    end
  end

  // Compare the presented PC against every valid entry; pick the lowest hit.
  always_comb begin
    bp_hit_vec   = '0;
    bp_first_idx = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_hit_vec[i] = bp_valid_q[i] && (bp_addr_q[i] == pc_i);
    end
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_hit_vec[i]) bp_first_idx = BPI_W'(i);
    end
    // The first instruction after leaving S_HALT must run even if it sits on a breakpoint.
    bp_match = !skip_q && (|bp_hit_vec);
  end

`ifdef RUNCTL_LIMIT_EN
  // This executed cycle is the last one the budget allows; zero disables it.
  assign limit_last = (cycle_limit_i != '0) &&
                      (cycle_cnt_q == cycle_limit_i - CNT_W'(1));
`else
  assign limit_last = 1'b0;
`endif

  // Next state, halt bookkeeping and the core clock-enable.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    bp_idx_d = bp_idx_q;
    skip_d   = skip_q;
    cpu_en   = 1'b0;
    unique case (state_q)
      S_HALT: begin
        // halt_i is meaningless here; step wins over run.
        if (step_i) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
        end else if (run_i) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
      S_STEP: begin
        cpu_en  = 1'b1;
        state_d = S_HALT;
        cause_d = halt_i ? CAUSE_HALT : CAUSE_STEP;
      end
      S_RUN: begin
        // A breakpoint instruction is never executed; a halt-cycle instruction is.
        cpu_en = !bp_match;
        if (halt_i) begin
          state_d = S_HALT;
          cause_d = CAUSE_HALT;
        end else if (bp_match) begin
          state_d  = S_HALT;
          cause_d  = CAUSE_BP;
          bp_idx_d = bp_first_idx;
        end else if (limit_last) begin
          state_d = S_HALT;
          cause_d = CAUSE_LIMIT;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    if (cpu_en) skip_d = 1'b0;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HALT;
      cause_q  <= CAUSE_NONE;
      bp_idx_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      bp_idx_q <= bp_idx_d;
      skip_q   <= skip_d;
    end
  end

  // Executed-cycle counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else if (cpu_en) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
    end
  end

  assign cpu_en_o     = cpu_en;
  assign halted_o     = (state_q == S_HALT);
  assign halt_cause_o = cause_q;
  assign bp_hit_idx_o = bp_idx_q;
  assign cycle_cnt_o  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl. A small core model advances the PC by 4
// on every enabled edge. The cycle-limit scenario builds with RUNCTL_LIMIT_EN.
module tb_cpu_run_ctrl;

  localparam int XLEN   = 32;
  localparam int CNT_W  = 32;
  localparam int NUM_BP = 2;
  localparam int BPI_W  = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run, step, halt;
  logic             bp_wr_en;
  logic [BPI_W-1:0] bp_wr_idx;
  logic [XLEN-1:0]  bp_wr_addr;
  logic             bp_wr_valid;
  logic [XLEN-1:0]  pc;
`ifdef RUNCTL_LIMIT_EN
  logic [CNT_W-1:0] cycle_limit;
`endif
  logic             cpu_en;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [BPI_W-1:0] bp_hit_idx;
  logic [CNT_W-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .NUM_BP(NUM_BP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run),
    .step_i       (step),
    .halt_i       (halt),
    .bp_wr_en_i   (bp_wr_en),
    .bp_wr_idx_i  (bp_wr_idx),
    .bp_wr_addr_i (bp_wr_addr),
    .bp_wr_valid_i(bp_wr_valid),
    .pc_i         (pc),
`ifdef RUNCTL_LIMIT_EN
    .cycle_limit_i(cycle_limit),
`endif
    .cpu_en_o     (cpu_en),
    .halted_o     (halted),
    .halt_cause_o (halt_cause),
    .bp_hit_idx_o (bp_hit_idx),
    .cycle_cnt_o  (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Core model: PC advances by one instruction on each enabled edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_run();
    run = 1'b1; tick(); run = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1; tick(); halt = 1'b0;
  endtask

  task automatic wr_bp(input logic [BPI_W-1:0] idx, input logic [XLEN-1:0] addr,
                       input logic valid);
    bp_wr_en = 1'b1; bp_wr_idx = idx; bp_wr_addr = addr; bp_wr_valid = valid;
    tick();
    bp_wr_en = 1'b0; bp_wr_valid = 1'b0;
  endtask

  // Samples cpu_en on n consecutive cycles, starting with the current one.
  task automatic count_en(input int n, output int c);
    c = 0;
    repeat (n) begin
      if (cpu_en === 1'b1) c++;
      tick();
    end
  endtask

  task automatic test_reset();
    int c;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (halted !== 1'b1)     begin $display("FAIL rst_halted: got %b want 1", halted); errors++; end
    checks++; if (cpu_en !== 1'b0)     begin $display("FAIL rst_cpu_en: got %b want 0", cpu_en); errors++; end
    checks++; if (halt_cause !== 3'b000) begin $display("FAIL rst_cause: got %b want 000", halt_cause); errors++; end
    checks++; if (cycle_cnt !== '0)    begin $display("FAIL rst_cnt: got %0d want 0", cycle_cnt); errors++; end
    checks++; if (bp_hit_idx !== '0)   begin $display("FAIL rst_idx: got %0d want 0", bp_hit_idx); errors++; end
    rst_n = 1'b1;
    count_en(10, c);
    checks++; if (c != 0) begin $display("FAIL idle_en: got %0d enable cycles want 0", c); errors++; end
    checks++; if (halted !== 1'b1) begin $display("FAIL idle_halted: got %b want 1", halted); errors++; end
  endtask

  task automatic test_step();
    int c;
    pulse_step();
    count_en(6, c);
    checks++; if (c != 1) begin $display("FAIL step_en_cycles: got %0d want 1", c); errors++; end
    checks++; if (cycle_cnt !== 32'd1) begin $display("FAIL step_cnt1: got %0d want 1", cycle_cnt); errors++; end
    checks++; if (halted !== 1'b1) begin $display("FAIL step_halted: got %b want 1", halted); errors++; end
    checks++; if (halt_cause !== 3'b010) begin $display("FAIL step_cause: got %b want 010", halt_cause); errors++; end
    pulse_step();
    count_en(4, c);
    checks++; if (cycle_cnt !== 32'd2) begin $display("FAIL step_cnt2: got %0d want 2", cycle_cnt); errors++; end
    checks++; if (pc !== 32'h8) begin $display("FAIL step_pc: got %0h want 8", pc); errors++; end
  endtask

  task automatic test_back_to_back();
    int c;
    // step and run together: step wins.
    step = 1'b1; run = 1'b1; tick(); step = 1'b0; run = 1'b0;
    count_en(5, c);
    checks++; if (c != 1) begin $display("FAIL both_en_cycles: got %0d want 1", c); errors++; end
    checks++; if (halt_cause !== 3'b010) begin $display("FAIL both_cause: got %b want 010", halt_cause); errors++; end
    // halt while already halted leaves the cause alone.
    pulse_halt();
    tick();
    checks++; if (halt_cause !== 3'b010) begin $display("FAIL halt_in_halt_cause: got %b want 010", halt_cause); errors++; end
    // halt during the step cycle: step still executes, cause becomes halt.
    pulse_step();
    halt = 1'b1;
    checks++; if (cpu_en !== 1'b1) begin $display("FAIL step_halt_en: got %b want 1", cpu_en); errors++; end
    tick(); halt = 1'b0;
    count_en(3, c);
    checks++; if (c != 0) begin $display("FAIL step_halt_extra_en: got %0d want 0", c); errors++; end
    checks++; if (halt_cause !== 3'b001) begin $display("FAIL step_halt_cause: got %b want 001", halt_cause); errors++; end
    checks++; if (cycle_cnt !== 32'd4) begin $display("FAIL step_halt_cnt: got %0d want 4", cycle_cnt); errors++; end
  endtask

  task automatic test_breakpoint();
    int c;
    do_reset();
    wr_bp(1'b0, 32'h0000_000C, 1'b1);
    pulse_run();
    count_en(8, c);
    checks++; if (c != 3) begin $display("FAIL bp_en_cycles: got %0d want 3", c); errors++; end
    checks++; if (cycle_cnt !== 32'd3) begin $display("FAIL bp_cnt: got %0d want 3", cycle_cnt); errors++; end
    checks++; if (halt_cause !== 3'b011) begin $display("FAIL bp_cause: got %b want 011", halt_cause); errors++; end
    checks++; if (bp_hit_idx !== 1'b0) begin $display("FAIL bp_idx: got %0d want 0", bp_hit_idx); errors++; end
    checks++; if (pc !== 32'hC) begin $display("FAIL bp_pc: got %0h want c", pc); errors++; end
    // Resume: the breakpoint instruction itself executes.
    pulse_run();
    checks++; if (cpu_en !== 1'b1) begin $display("FAIL resume_en: got %b want 1", cpu_en); errors++; end
    tick();
    checks++; if (cycle_cnt !== 32'd4) begin $display("FAIL resume_cnt: got %0d want 4", cycle_cnt); errors++; end
    tick(); tick();
    checks++; if (halted !== 1'b0) begin $display("FAIL resume_rehalt: got halted=%b want 0", halted); errors++; end
    pulse_halt();
    checks++; if (halted !== 1'b1 || halt_cause !== 3'b001)
      begin $display("FAIL run_halt: got halted=%b cause=%b want 1/001", halted, halt_cause); errors++; end
    checks++; if (cycle_cnt !== 32'd7) begin $display("FAIL run_halt_cnt: got %0d want 7", cycle_cnt); errors++; end
  endtask

  task automatic test_halt_with_bp();
    do_reset();
    wr_bp(1'b1, 32'h0000_0010, 1'b1);
    pulse_run();
    for (int k = 0; k < 50 && pc !== 32'h10; k++) tick();
    checks++; if (pc !== 32'h10) begin $display("FAIL hb_timeout: pc got %0h want 10", pc); errors++; end
    checks++; if (cpu_en !== 1'b0) begin $display("FAIL hb_en: got %b want 0", cpu_en); errors++; end
    pulse_halt();
    checks++; if (halted !== 1'b1 || halt_cause !== 3'b001)
      begin $display("FAIL hb_cause: got halted=%b cause=%b want 1/001", halted, halt_cause); errors++; end
    checks++; if (cycle_cnt !== 32'd4) begin $display("FAIL hb_cnt: got %0d want 4", cycle_cnt); errors++; end
    // Two entries on the same PC: the lower index is reported.
    wr_bp(1'b1, 32'h0000_0018, 1'b1);
    wr_bp(1'b0, 32'h0000_0018, 1'b1);
    pulse_run();
    for (int k = 0; k < 50 && halted !== 1'b1; k++) tick();
    checks++; if (halt_cause !== 3'b011 || pc !== 32'h18)
      begin $display("FAIL dual_bp: got cause=%b pc=%0h want 011/18", halt_cause, pc); errors++; end
    checks++; if (bp_hit_idx !== 1'b0) begin $display("FAIL dual_idx: got %0d want 0", bp_hit_idx); errors++; end
    checks++; if (cycle_cnt !== 32'd6) begin $display("FAIL dual_cnt: got %0d want 6", cycle_cnt); errors++; end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    wr_bp(1'b1, 32'h0000_0040, 1'b1);
    pulse_run();
    for (int k = 0; k < 50 && cycle_cnt !== 32'd7; k++) tick();
    checks++; if (cycle_cnt !== 32'd7 || halted !== 1'b0)
      begin $display("FAIL mid_pre: got cnt=%0d halted=%b want 7/0", cycle_cnt, halted); errors++; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || cpu_en !== 1'b0)
      begin $display("FAIL mid_async: got halted=%b en=%b want 1/0", halted, cpu_en); errors++; end
    checks++; if (cycle_cnt !== '0 || halt_cause !== 3'b000)
      begin $display("FAIL mid_async_vals: got cnt=%0d cause=%b want 0/000", cycle_cnt, halt_cause); errors++; end
    repeat (2) tick();
    rst_n = 1'b1;
    pulse_run();
    for (int k = 0; k < 50 && pc !== 32'h48; k++) tick();
    checks++; if (pc !== 32'h48 || halted !== 1'b0)
      begin $display("FAIL mid_bp_cleared: got pc=%0h halted=%b want 48/0", pc, halted); errors++; end
    pulse_halt();
  endtask

`ifdef RUNCTL_LIMIT_EN
  task automatic test_limit();
    int c;
    cycle_limit = 32'd21;
    do_reset();
    pulse_run();
    count_en(40, c);
    checks++; if (c != 21) begin $display("FAIL lim_en_cycles: got %0d want 21", c); errors++; end
    checks++; if (halted !== 1'b1 || halt_cause !== 3'b100)
      begin $display("FAIL lim_cause: got halted=%b cause=%b want 1/100", halted, halt_cause); errors++; end
    checks++; if (cycle_cnt !== 32'd21) begin $display("FAIL lim_cnt: got %0d want 21", cycle_cnt); errors++; end
    cycle_limit = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0;
    bp_wr_en = 1'b0; bp_wr_idx = '0; bp_wr_addr = '0; bp_wr_valid = 1'b0;
`ifdef RUNCTL_LIMIT_EN
    cycle_limit = '0;
`endif
    test_reset();
    test_step();
    test_back_to_back();
    test_breakpoint();
    test_halt_with_bp();
    test_reset_mid_run();
`ifdef RUNCTL_LIMIT_EN
    test_limit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
